// File: rtl/kpn_multiplier_process.sv
// kpn_multiplier_process: KPN multiply/MAC process node with credit-gated input and a result FIFO
module kpn_multiplier_process #(
    parameter int DATA_W      = 16,
    parameter int GUARD_BITS  = 0,
    parameter int PIPE_STAGES = 2,
    parameter int OUT_DEPTH   = 4,
    parameter int ACC_LEN     = 4,
    parameter bit SIGNED      = 1'b0,
    localparam int OUT_W      = 2 * DATA_W + GUARD_BITS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] entry_1,
    input  logic              entry_1_valid,
    output logic              entry_1_ready,
    input  logic [DATA_W-1:0] entry_2,
    input  logic              entry_2_valid,
    output logic              entry_2_ready,
    input  logic              mode_mac,
    output logic [OUT_W-1:0]  output_1,
    output logic              output_1_valid,
    input  logic              output_1_ready,
    output logic [15:0]       tokens_out
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + PIPE_STAGES + 1) + 1;
    localparam int GW = $clog2(ACC_LEN + 1);
    localparam int LS = PIPE_STAGES - 1;

    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic [OUT_W-1:0]           prod;
    logic [OUT_W-1:0]           pipe_p [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]     pipe_v, pipe_e, pipe_m;
    logic [OUT_W-1:0]           res, acc, last, sum;
    logic                       res_v;
    logic [OUT_W-1:0]           mem [OUT_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;
    logic [GW-1:0]              grp;
    logic                       mode, mode_eff, idle, emit_n, credit_ok, fire_ok, fire, pop;
    logic [CW-1:0]              inflight;

    assign prod_s = (2*DATA_W)'($signed(entry_1)) * (2*DATA_W)'($signed(entry_2));
    assign prod_u = (2*DATA_W)'(entry_1) * (2*DATA_W)'(entry_2);
    assign prod   = SIGNED ? OUT_W'(prod_s) : OUT_W'(prod_u);
    assign sum    = acc + pipe_p[LS];

    // Results already owed to the FIFO: emitting pipeline entries plus the result register
    always_comb begin
        inflight = CW'(res_v);
        for (int i = 0; i < PIPE_STAGES; i++) inflight += CW'(pipe_v[i] & pipe_e[i]);
    end

    // A new mode is only taken when nothing is in flight and no MAC group is open
    assign idle      = ~|pipe_v & ~res_v & (count == '0) & (grp == '0);
    assign mode_eff  = idle ? mode_mac : mode;
    assign emit_n    = ~mode_eff | (grp == GW'(ACC_LEN - 1));
    assign credit_ok = (inflight + CW'(count)) < CW'(OUT_DEPTH);
    assign fire_ok   = credit_ok | ~emit_n;
    assign entry_1_ready  = fire_ok & entry_2_valid;
    assign entry_2_ready  = fire_ok & entry_1_valid;
    assign fire           = entry_1_valid & entry_2_valid & fire_ok;
    assign output_1_valid = count != '0;
    assign output_1       = output_1_valid ? mem[rd_ptr] : last;
    assign pop            = output_1_valid & output_1_ready;

    // Multiply pipeline, each entry tagged with its mode and whether it closes a result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            pipe_e <= '0;
            pipe_m <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) pipe_p[i] <= '0;
        end else begin
            for (int i = PIPE_STAGES - 1; i > 0; i--) begin
                pipe_p[i] <= pipe_p[i-1];
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_m[i] <= pipe_m[i-1];
            end
            pipe_p[0] <= prod;
            pipe_v[0] <= fire;
            pipe_e[0] <= emit_n;
            pipe_m[0] <= mode_eff;
        end
    end

    // Result stage: pass products through in MUL, accumulate and emit on group close in MAC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_v <= 1'b0;
            res   <= '0;
            acc   <= '0;
        end else begin
            res_v <= pipe_v[LS] & pipe_e[LS];
            if (pipe_v[LS]) begin
                res <= pipe_m[LS] ? sum : pipe_p[LS];
                if (pipe_m[LS]) acc <= pipe_e[LS] ? '0 : sum;
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (res_v) mem[wr_ptr] <= res;
    end

    // FIFO pointers, occupancy and the last popped value shown while empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (res_v) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(res_v) - (AW+1)'(pop);
        end
    end

    // Mode register, MAC group position and popped-token counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode       <= 1'b0;
            grp        <= '0;
            tokens_out <= '0;
        end else begin
            mode       <= mode_eff;
            tokens_out <= tokens_out + 16'(pop);
            if (fire & mode_eff) grp <= emit_n ? '0 : grp + GW'(1);
        end
    end
endmodule

// File: tb/tb_kpn_multiplier_process.sv
// tb_kpn_multiplier_process: directed and random checks of MUL/MAC, credits, mode hold and reset
module tb_kpn_multiplier_process;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] e1d [2];
    logic [15:0] e2d [2];
    logic        e1v [2];
    logic        e2v [2];
    logic        e1r [2];
    logic        e2r [2];
    logic        mm [2];
    logic [31:0] o [2];
    logic        ov [2];
    logic        out_r [2];
    logic [15:0] tokens [2];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sa_q [$];
    logic [15:0] sb_q [$];
    logic [31:0] expq [$];
    bit          va, vb, mode_m;
    int          fires, cnt_m, lat;
    int          tok [2];
    logic [31:0] acc_m, lastpop;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        kpn_multiplier_process #(.SIGNED(g == 1), .ACC_LEN(g == 1 ? 3 : 4)) u_dut (
            .clk(clk), .reset_n(rst_n),
            .entry_1(e1d[g]), .entry_1_valid(e1v[g]), .entry_1_ready(e1r[g]),
            .entry_2(e2d[g]), .entry_2_valid(e2v[g]), .entry_2_ready(e2r[g]),
            .mode_mac(mm[g]),
            .output_1(o[g]), .output_1_valid(ov[g]), .output_1_ready(out_r[g]),
            .tokens_out(tokens[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mul_ref(input int k, input logic [15:0] a, input logic [15:0] b);
        shortint sa, sb;
        sa = a;
        sb = b;
        if (k == 1) return 32'(int'(sa) * int'(sb));
        return {16'b0, a} * {16'b0, b};
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        sa_q.push_back(a);
        sb_q.push_back(b);
    endtask

    task automatic model_fire(input int k);
        logic [31:0] p;
        if (expq.size() == 0 && cnt_m == 0) mode_m = mm[k];
        p = mul_ref(k, sa_q.pop_front(), sb_q.pop_front());
        if (!mode_m) expq.push_back(p);
        else begin
            acc_m += p;
            cnt_m++;
            if (cnt_m == (k == 1 ? 3 : 4)) begin
                expq.push_back(acc_m);
                acc_m = 0;
                cnt_m = 0;
            end
        end
    endtask

    task automatic drive(input int k, input int rmode);
        if (sa_q.size() != 0 && !va) va = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sa_q.size() != 0 && !vb) vb = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        e1v[k] = va;
        e2v[k] = vb;
        e1d[k] = sa_q.size() != 0 ? sa_q[0] : 16'h0;
        e2d[k] = sb_q.size() != 0 ? sb_q[0] : 16'h0;
        out_r[k] = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic process(input int k);
        if (va != vb) check("one_sided", va ? e1r[k] : e2r[k], 0);
        if (va && vb) begin
            check("ready_pair", e1r[k], e2r[k]);
            if (e1r[k]) begin
                model_fire(k);
                fires++;
                va = 0;
                vb = 0;
            end
        end
        if (ov[k] && out_r[k]) begin
            if (expq.size() == 0) check("spurious", 1, 0);
            else begin
                lastpop = expq.pop_front();
                check("data", o[k], lastpop);
            end
            tok[k]++;
        end
    endtask

    task automatic run(input int k, input int rmode, input int ncyc, input bit drain);
        bit done;
        done = 0;
        drive(k, rmode);
        for (int c = 0; c < ncyc && !done; c++) begin
            @(negedge clk);
            process(k);
            @(posedge clk);
            #1;
            drive(k, rmode);
            done = drain && sa_q.size() == 0 && expq.size() == 0 && !va && !vb;
        end
        if (drain && !done) check("timeout", 0, 1);
    endtask

    task automatic tok_check(input int k);
        @(negedge clk);
        check("tokens", 32'(tokens[k]), 32'(tok[k][15:0]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            e1d[k] = 0; e2d[k] = 0; e1v[k] = 0; e2v[k] = 0; mm[k] = 0; out_r[k] = 0; tok[k] = 0;
        end
        va = 0; vb = 0; mode_m = 0; cnt_m = 0; acc_m = 0; fires = 0; lastpop = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", 32'(ov[k]), 0);
            check("rst_out", o[k], 0);
            check("rst_tokens", 32'(tokens[k]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency of a single pair into an empty node
        e1d[0] = 3; e2d[0] = 4; e1v[0] = 1; e2v[0] = 1; out_r[0] = 1;
        @(negedge clk);
        check("lat_ready", 32'(e1r[0]), 1);
        @(posedge clk);
        #1;
        e1v[0] = 0; e2v[0] = 0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 3);
        check("lat_data", o[0], 12);
        tok[0]++;
        @(posedge clk);
        #1;
        out_r[0] = 0;
        @(negedge clk);
        check("empty_valid", 32'(ov[0]), 0);
        check("hold_last", o[0], 12);
        @(posedge clk);
        #1;

        // MUL ordering
        push(20, 20); push(5, 5); push(10, 9);
        run(0, 1, 100, 1);
        check("t1_last", lastpop, 90);

        // signed vs unsigned interpretation of the same bits
        push(16'hFFFD, 7);
        run(1, 1, 100, 1);
        check("t2_signed", lastpop, 32'hFFFFFFEB);
        push(16'hFFFD, 7);
        run(0, 1, 100, 1);
        check("t2_unsigned", lastpop, 32'h0006FFEB);

        // backpressure: only OUT_DEPTH credits
        fires = 0;
        for (int i = 0; i < 6; i++) push(16'(i + 2), 16'(i + 11));
        run(0, 0, 12, 0);
        check("bp_accepted", fires, 4);
        @(negedge clk);
        check("bp_ready1", 32'(e1r[0]), 0);
        check("bp_ready2", 32'(e2r[0]), 0);
        check("bp_valid", 32'(ov[0]), 1);
        check("bp_head", o[0], expq[0]);
        @(posedge clk);
        #1;
        run(0, 1, 200, 1);
        check("bp_total", fires, 6);
        tok_check(0);

        // valid skew: nothing consumed until both valid
        e1d[0] = 7; e2d[0] = 6; e1v[0] = 1; e2v[0] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("skew_ready", 32'(e1r[0]), 0);
            @(posedge clk);
            #1;
        end
        push(7, 6);
        va = 1;
        run(0, 1, 100, 1);
        check("skew_data", lastpop, 42);

        // MAC groups of three
        mm[1] = 1;
        push(20, 20); push(5, 5); push(10, 9);
        run(1, 1, 100, 1);
        check("t5_mac", lastpop, 515);
        push(1, 1); push(2, 2); push(3, 3);
        run(1, 1, 100, 1);
        check("t5_restart", lastpop, 14);
        tok_check(1);

        // reset with a partial group in flight
        push(20, 20); push(5, 5);
        run(1, 1, 6, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", 32'(ov[1]), 0);
        check("mid_rst_out", o[1], 0);
        check("mid_rst_tokens", 32'(tokens[1]), 0);
        expq.delete(); acc_m = 0; cnt_m = 0; mode_m = 0; tok[0] = 0; tok[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1, 2); push(3, 4); push(5, 6);
        run(1, 1, 100, 1);
        check("t6_group", lastpop, 44);
        tok_check(1);

        // mode request during an open group is ignored until the group closes
        push(2, 3);
        run(1, 1, 5, 0);
        mm[1] = 0;
        push(4, 5); push(1, 1);
        run(1, 1, 200, 1);
        check("mode_hold", lastpop, 27);

        // random traffic, modes switched only between complete groups
        for (int it = 0; it < 12; it++) begin
            int k, n;
            k = it % 2;
            mm[k] = 1'($urandom_range(0, 1));
            n = mm[k] ? (k == 1 ? 3 : 4) * int'($urandom_range(1, 4)) : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) push(16'($urandom), 16'($urandom));
            run(k, 2, 2000, 1);
            tok_check(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
